// File: rtl/edge_gen_pkg.sv
// Shared definitions for the edge/level generator: FSM encoding, default
// counter width and the effective-hold helper.
package edge_gen_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam int unsigned CNT_W_DEF = 8;

   // Effective hold length: the commanded hold, but never below the floor.
   function automatic logic [31:0] eff_hold(input logic [31:0] hold,
                                            input logic [31:0] min_hold);
      return (hold > min_hold) ? hold : min_hold;
   endfunction

endpackage

// File: rtl/edge_gen_hold_counter.sv
// Down-counter that times the HOLD phase. Loads the effective hold on an
// accept, decrements while holding, saturates at zero (never wraps) and flags
// the last hold cycle.
module hold_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             is_last_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: load has priority, decrement stops at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o     = cnt_q;
   assign is_last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/edge_gen.sv
// Edge/level generator. Accepts level commands over valid/ready, drives a
// registered level a_o, holds each new level for max(cmd_hold_i, MIN_HOLD)
// cycles and emits one-cycle rising/falling strobes aligned with a_o changes.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid_i and
// cmd_ready_o are both high; cmd_* are sampled only then. While busy the
// source must keep cmd_valid_i and its payload stable; nothing is queued.
module edge_gen
   import edge_gen_pkg::*;
#(
   parameter int unsigned CNT_W    = CNT_W_DEF,
   parameter int unsigned MIN_HOLD = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic             cmd_level_i,
   input  logic [CNT_W-1:0] cmd_hold_i,
   output logic             a_o,
   output logic             rising_edge_o,
   output logic             falling_edge_o,
   output logic             busy_o,
   output state_t           dbg_state_o,
   output logic [CNT_W-1:0] dbg_cnt_o
);

   state_t           state_q;
   logic             a_q;
   logic             rise_q;
   logic             fall_q;
   logic [CNT_W-1:0] hold_eff;
   logic             hold_nz;
   logic             accept;
   logic             cnt_last;

   assign hold_eff = CNT_W'(eff_hold(32'(cmd_hold_i), MIN_HOLD));
   assign hold_nz  = |hold_eff;
   assign accept   = cmd_valid_i && (state_q == IDLE);

   hold_counter #(
      .CNT_W (CNT_W)
   ) u_hold_counter (
      .clk        (clk),
      .reset      (reset),
      .load_i     (accept && hold_nz),
      .load_val_i (hold_eff),
      .dec_i      (state_q == HOLD),
      .cnt_o      (dbg_cnt_o),
      .is_last_o  (cnt_last)
   );

   // FSM plus level and strobe registers; strobes are cleared every cycle
   // unless an accept changes the level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q    <= cmd_level_i;
                  rise_q <= ~a_q & cmd_level_i;
                  fall_q <= a_q & ~cmd_level_i;
                  if (hold_nz) begin
                     state_q <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (cnt_last) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready_o    = (state_q == IDLE);
   assign busy_o         = (state_q == HOLD);
   assign a_o            = a_q;
   assign rising_edge_o  = rise_q;
   assign falling_edge_o = fall_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_edge_gen.sv
// Bench for edge_gen: one instance with MIN_HOLD=0 and one with MIN_HOLD=4,
// checked against a remaining-busy-cycles reference model.
module tb_edge_gen;
   import edge_gen_pkg::*;

   localparam int CW = 8;

   logic clk;
   logic reset;

   // Instance 0 (MIN_HOLD = 0)
   logic          v0, l0;
   logic [CW-1:0] h0;
   logic          rdy0, a0, r0, f0, busy0;
   state_t        st0;
   logic [CW-1:0] cnt0;

   // Instance 4 (MIN_HOLD = 4)
   logic          v4, l4;
   logic [CW-1:0] h4;
   logic          rdy4, a4, r4, f4, busy4;
   state_t        st4;
   logic [CW-1:0] cnt4;

   int checks = 0;
   int errors = 0;

   // Reference model: current level, strobes of this cycle, busy cycles left.
   bit m0_a, m0_r, m0_f;
   int m0_left;
   bit m4_a, m4_r, m4_f;
   int m4_left;

   logic [4:0] obs0, obs4;
   assign obs0 = {a0, r0, f0, rdy0, busy0};
   assign obs4 = {a4, r4, f4, rdy4, busy4};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   edge_gen #(.CNT_W(CW), .MIN_HOLD(0)) dut0 (
      .clk (clk), .reset (reset),
      .cmd_valid_i (v0), .cmd_ready_o (rdy0), .cmd_level_i (l0), .cmd_hold_i (h0),
      .a_o (a0), .rising_edge_o (r0), .falling_edge_o (f0), .busy_o (busy0),
      .dbg_state_o (st0), .dbg_cnt_o (cnt0)
   );

   edge_gen #(.CNT_W(CW), .MIN_HOLD(4)) dut4 (
      .clk (clk), .reset (reset),
      .cmd_valid_i (v4), .cmd_ready_o (rdy4), .cmd_level_i (l4), .cmd_hold_i (h4),
      .a_o (a4), .rising_edge_o (r4), .falling_edge_o (f4), .busy_o (busy4),
      .dbg_state_o (st4), .dbg_cnt_o (cnt4)
   );

   function automatic logic [4:0] exp0();
      return {m0_a, m0_r, m0_f, m0_left == 0, m0_left != 0};
   endfunction

   function automatic logic [4:0] exp4();
      return {m4_a, m4_r, m4_f, m4_left == 0, m4_left != 0};
   endfunction

   task automatic model_clear();
      m0_a = 0; m0_r = 0; m0_f = 0; m0_left = 0;
      m4_a = 0; m4_r = 0; m4_f = 0; m4_left = 0;
   endtask

   // Advance one clock: update the model from the inputs present at the edge,
   // then move 1 time unit past the edge so outputs are settled.
   task automatic step();
      int hh;
      @(posedge clk);
      m0_r = 0; m0_f = 0;
      if (m0_left > 0) begin
         m0_left--;
      end else if (v0) begin
         m0_r = !m0_a && l0;
         m0_f = m0_a && !l0;
         m0_a = l0;
         m0_left = int'(h0);
      end
      m4_r = 0; m4_f = 0;
      if (m4_left > 0) begin
         m4_left--;
      end else if (v4) begin
         m4_r = !m4_a && l4;
         m4_f = m4_a && !l4;
         m4_a = l4;
         hh = int'(h4);
         m4_left = (hh > 4) ? hh : 4;
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      v0 = 0; l0 = 0; h0 = '0;
      v4 = 0; l4 = 0; h4 = '0;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (obs0 !== 5'b00010 || obs4 !== 5'b00010) begin
         errors++;
         $display("FAIL reset_state: got %b/%b want 00010", obs0, obs4);
      end
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if (obs0 !== 5'b00010) begin
            errors++;
            $display("FAIL reset_idle cyc%0d: got %b want 00010", i, obs0);
         end
      end
   endtask

   task automatic test_single();
      int n;
      v0 = 1; l0 = 1; h0 = 8'd3;
      step();
      v0 = 0;
      checks++;
      if (obs0 !== 5'b11001) begin
         errors++;
         $display("FAIL single_accept: got %b want 11001", obs0);
      end
      n = 1;
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if (obs0 !== exp0()) begin
            errors++;
            $display("FAIL single_hold cyc%0d: got %b want %b", i, obs0, exp0());
         end
         if (rdy0 === 1'b1) break;
         n++;
      end
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL single_busy_len: got %0d want 3", n);
      end
      v0 = 1; l0 = 0; h0 = 8'd0;
      step();
      v0 = 0;
      checks++;
      if (obs0 !== 5'b00110) begin
         errors++;
         $display("FAIL single_fall: got %b want 00110", obs0);
      end
      step();
      checks++;
      if (obs0 !== 5'b00010) begin
         errors++;
         $display("FAIL single_fall_clear: got %b want 00010", obs0);
      end
   endtask

   task automatic test_back_to_back();
      bit         lv[4];
      logic [1:0] sv[4];
      lv = '{1'b1, 1'b0, 1'b1, 1'b1};
      sv = '{2'b10, 2'b01, 2'b10, 2'b00};
      for (int i = 0; i < 4; i++) begin
         v0 = 1; l0 = lv[i]; h0 = 8'd0;
         step();
         checks++;
         if ({a0, r0, f0, rdy0} !== {lv[i], sv[i], 1'b1}) begin
            errors++;
            $display("FAIL b2b cmd%0d: got %b want %b", i, {a0, r0, f0, rdy0}, {lv[i], sv[i], 1'b1});
         end
      end
      v0 = 0;
      step();
      checks++;
      if (obs0 !== 5'b10010) begin
         errors++;
         $display("FAIL b2b_after: got %b want 10010", obs0);
      end
   endtask

   task automatic test_min_hold();
      int n;
      v4 = 1; l4 = 1; h4 = 8'd1;
      step();
      l4 = 0; h4 = 8'd0;
      checks++;
      if (obs4 !== 5'b11001) begin
         errors++;
         $display("FAIL minhold_accept: got %b want 11001", obs4);
      end
      n = 1;
      for (int i = 0; i < 20; i++) begin
         step();
         checks++;
         if (obs4 !== exp4()) begin
            errors++;
            $display("FAIL minhold_hold cyc%0d: got %b want %b", i, obs4, exp4());
         end
         if (rdy4 === 1'b1) break;
         n++;
      end
      checks++;
      if (n != 4 || a4 !== 1'b1) begin
         errors++;
         $display("FAIL minhold_len: got %0d a=%b want 4 a=1", n, a4);
      end
      step();
      v4 = 0;
      checks++;
      if (obs4 !== 5'b00101) begin
         errors++;
         $display("FAIL minhold_second: got %b want 00101", obs4);
      end
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (obs4 !== exp4()) begin
            errors++;
            $display("FAIL minhold_drain cyc%0d: got %b want %b", i, obs4, exp4());
         end
      end
   endtask

   task automatic test_hold_max();
      int n;
      v0 = 1; l0 = 1; h0 = 8'd255;
      step();
      v0 = 0;
      n = 1;
      for (int i = 0; i < 300; i++) begin
         step();
         checks++;
         if (obs0 !== exp0()) begin
            errors++;
            $display("FAIL holdmax cyc%0d: got %b want %b", i, obs0, exp0());
         end
         if (rdy0 === 1'b1) break;
         n++;
      end
      checks++;
      if (n != 255) begin
         errors++;
         $display("FAIL holdmax_len: got %0d want 255", n);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (obs0 !== 5'b10010) begin
            errors++;
            $display("FAIL holdmax_nowrap cyc%0d: got %b want 10010", i, obs0);
         end
      end
   endtask

   task automatic test_reset_mid_hold();
      v0 = 1; l0 = 1; h0 = 8'd10;
      step();
      v0 = 0;
      repeat (3) step();
      checks++;
      if ({a0, busy0} !== 2'b11) begin
         errors++;
         $display("FAIL midhold_pre: got a=%b busy=%b want 1 1", a0, busy0);
      end
      reset = 1'b1;
      #1;
      model_clear();
      checks++;
      if (obs0 !== 5'b00010) begin
         errors++;
         $display("FAIL midhold_async: got %b want 00010", obs0);
      end
      @(negedge clk);
      reset = 1'b0;
      step();
      checks++;
      if (obs0 !== 5'b00010) begin
         errors++;
         $display("FAIL midhold_release: got %b want 00010", obs0);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         v0 = 1'($urandom_range(0, 1));
         l0 = 1'($urandom_range(0, 1));
         h0 = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(4, 12)) : CW'($urandom_range(0, 2));
         v4 = 1'($urandom_range(0, 1));
         l4 = 1'($urandom_range(0, 1));
         h4 = CW'($urandom_range(0, 6));
         step();
         checks++;
         if (obs0 !== exp0() || obs4 !== exp4()) begin
            errors++;
            $display("FAIL random cyc%0d: got %b/%b want %b/%b", i, obs0, obs4, exp0(), exp4());
         end
      end
      v0 = 0; v4 = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_min_hold();
      test_hold_max();
      test_reset_mid_hold();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
